// File: rtl/ddr_arb_pkg.sv
// rtl/ddr_arb_pkg.sv - shared types and constants for the DDR AXI arbiter
// Holds the FSM state encoding, the last-served side encoding, the AXI OKAY
// response code and the default AXI widths shared with ddr_ctrl_top.
package ddr_arb_pkg;

   localparam int DDR_AXI_ADDR_WIDTH  = 32;
   localparam int DDR_AXI_DATA_WIDTH  = 128;
   localparam int DDR_AXI_ID_WIDTH    = 1;
   localparam int DDR_AXI_BURST_WIDTH = 6;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_ADDR = 3'd1,
      ST_WR_DATA = 3'd2,
      ST_WR_RESP = 3'd3,
      ST_RD_ADDR = 3'd4,
      ST_RD_DATA = 3'd5
   } arb_state_e;

   typedef enum logic {
      SIDE_WR = 1'b0,
      SIDE_RD = 1'b1
   } arb_side_e;

endpackage

// File: rtl/ddr_arb_rr.sv
// rtl/ddr_arb_rr.sv - two-input grant selection (round-robin or read priority)
// Build option: DDR_ARB_RD_PRIO_EN selects fixed read priority instead of
// round-robin.
// Ports:
//   clk_i, resetn_i     clock and synchronous active-low reset
//   req_wr_i, req_rd_i  pending requests
//   accept_i            a grant is being issued this cycle
//   win_wr_o, win_rd_o  which side would be granted (one-hot or zero)
module ddr_arb_rr
   import ddr_arb_pkg::*;
(
   input  logic clk_i,
   input  logic resetn_i,
   input  logic req_wr_i,
   input  logic req_rd_i,
   input  logic accept_i,
   output logic win_wr_o,
   output logic win_rd_o
);

`ifdef DDR_ARB_RD_PRIO_EN
   // The real-time read path wins every tie; no history is kept.
   assign win_rd_o = req_rd_i;
   assign win_wr_o = req_wr_i & ~req_rd_i;

   logic unused_rr;
   assign unused_rr = ^{clk_i, resetn_i, accept_i};
`else
   arb_side_e last_served_q;
   arb_side_e last_served_d;

   // On a tie, serve the side that did not go last. Reset value SIDE_RD makes
   // the write path win the first tie.
   always_comb begin
      win_wr_o = 1'b0;
      win_rd_o = 1'b0;
      if (req_wr_i && req_rd_i) begin
         win_wr_o = (last_served_q == SIDE_RD);
         win_rd_o = (last_served_q == SIDE_WR);
      end else begin
         win_wr_o = req_wr_i;
         win_rd_o = req_rd_i;
      end
   end

   always_comb begin
      last_served_d = last_served_q;
      if (accept_i) begin
         last_served_d = win_rd_o ? SIDE_RD : SIDE_WR;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         last_served_q <= SIDE_RD;
      end else begin
         last_served_q <= last_served_d;
      end
   end
`endif

endmodule

// File: rtl/ddr_axi_arbiter.sv
// rtl/ddr_axi_arbiter.sv - shares one AXI master port between a write and a read requester
// Build option: DDR_ARB_RD_PRIO_EN (read wins every tie; default round-robin).
// Ports:
//   aclk, aresetn                 clock, synchronous active-low reset
//   wr_req/wr_addr/wr_len         write burst request, sampled at wr_grant
//   wr_grant, wr_done             write grant pulse, pulse after B handshake
//   wr_data/wr_data_valid/ready   write beat stream
//   rd_req/rd_addr/rd_len         read burst request, sampled at rd_grant
//   rd_grant, rd_done             read grant pulse, pulse on last R beat
//   rd_data/rd_data_valid         read beat stream (always accepted)
//   resp_err                      sticky non-OKAY response flag
//   ddr_aw*/w*/b*/ar*/r*          AXI master interface
module ddr_axi_arbiter
   import ddr_arb_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH  = DDR_AXI_ADDR_WIDTH,
   parameter int AXI_DATA_WIDTH  = DDR_AXI_DATA_WIDTH,
   parameter int AXI_ID_WIDTH    = DDR_AXI_ID_WIDTH,
   parameter int AXI_BURST_WIDTH = DDR_AXI_BURST_WIDTH
)
(
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        wr_req,
   input  logic [AXI_ADDR_WIDTH-1:0]   wr_addr,
   input  logic [AXI_BURST_WIDTH-1:0]  wr_len,
   output logic                        wr_grant,
   input  logic [AXI_DATA_WIDTH-1:0]   wr_data,
   input  logic                        wr_data_valid,
   output logic                        wr_data_ready,
   output logic                        wr_done,
   input  logic                        rd_req,
   input  logic [AXI_ADDR_WIDTH-1:0]   rd_addr,
   input  logic [AXI_BURST_WIDTH-1:0]  rd_len,
   output logic                        rd_grant,
   output logic [AXI_DATA_WIDTH-1:0]   rd_data,
   output logic                        rd_data_valid,
   output logic                        rd_done,
   output logic                        resp_err,
   output logic [AXI_ID_WIDTH-1:0]     ddr_awid,
   output logic [AXI_ADDR_WIDTH-1:0]   ddr_awaddr,
   output logic [AXI_BURST_WIDTH-1:0]  ddr_awlen,
   output logic                        ddr_awvalid,
   input  logic                        ddr_awready,
   output logic [AXI_DATA_WIDTH-1:0]   ddr_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] ddr_wstrb,
   output logic                        ddr_wlast,
   output logic                        ddr_wvalid,
   input  logic                        ddr_wready,
   input  logic [AXI_ID_WIDTH-1:0]     ddr_bid,
   input  logic [1:0]                  ddr_bresp,
   input  logic                        ddr_bvalid,
   output logic                        ddr_bready,
   output logic [AXI_ID_WIDTH-1:0]     ddr_arid,
   output logic [AXI_ADDR_WIDTH-1:0]   ddr_araddr,
   output logic [AXI_BURST_WIDTH-1:0]  ddr_arlen,
   output logic                        ddr_arvalid,
   input  logic                        ddr_arready,
   input  logic [AXI_ID_WIDTH-1:0]     ddr_rid,
   input  logic [AXI_DATA_WIDTH-1:0]   ddr_rdata,
   input  logic [1:0]                  ddr_rresp,
   input  logic                        ddr_rvalid,
   output logic                        ddr_rready,
   input  logic                        ddr_rlast
);

   arb_state_e                 state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [AXI_BURST_WIDTH-1:0] len_q, len_d;
   logic [AXI_BURST_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
   logic                       resp_err_q, resp_err_d;
   logic                       wr_done_q, wr_done_d;

   logic win_wr, win_rd;
   logic in_idle;
   logic w_fire;
   logic w_last_beat;

   // Single ID, single outstanding transaction: response IDs carry no information.
   logic unused_ids;
   assign unused_ids = ^{ddr_bid, ddr_rid};

   assign in_idle     = (state_q == ST_IDLE) && aresetn;
   assign wr_grant    = in_idle && win_wr;
   assign rd_grant    = in_idle && win_rd;
   assign w_last_beat = (beat_cnt_q == len_q);
   assign w_fire      = (state_q == ST_WR_DATA) && wr_data_valid && ddr_wready;

   ddr_arb_rr u_rr (
      .clk_i    (aclk),
      .resetn_i (aresetn),
      .req_wr_i (wr_req),
      .req_rd_i (rd_req),
      .accept_i (wr_grant | rd_grant),
      .win_wr_o (win_wr),
      .win_rd_o (win_rd)
   );

   // State register
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (wr_grant) begin
               state_d = ST_WR_ADDR;
            end else if (rd_grant) begin
               state_d = ST_RD_ADDR;
            end
         end
         ST_WR_ADDR: if (ddr_awready) state_d = ST_WR_DATA;
         ST_WR_DATA: if (w_fire && w_last_beat) state_d = ST_WR_RESP;
         ST_WR_RESP: if (ddr_bvalid) state_d = ST_IDLE;
         ST_RD_ADDR: if (ddr_arready) state_d = ST_RD_DATA;
         ST_RD_DATA: if (ddr_rvalid && ddr_rlast) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      ddr_awvalid   = 1'b0;
      ddr_wvalid    = 1'b0;
      ddr_wdata     = '0;
      ddr_wstrb     = '0;
      ddr_wlast     = 1'b0;
      wr_data_ready = 1'b0;
      ddr_bready    = 1'b0;
      ddr_arvalid   = 1'b0;
      ddr_rready    = 1'b0;
      rd_data       = '0;
      rd_data_valid = 1'b0;
      rd_done       = 1'b0;
      case (state_q)
         ST_WR_ADDR: ddr_awvalid = 1'b1;
         ST_WR_DATA: begin
            ddr_wvalid    = wr_data_valid;
            ddr_wdata     = wr_data;
            ddr_wstrb     = '1;
            ddr_wlast     = w_last_beat;
            wr_data_ready = ddr_wready;
         end
         ST_WR_RESP: ddr_bready = 1'b1;
         ST_RD_ADDR: ddr_arvalid = 1'b1;
         ST_RD_DATA: begin
            ddr_rready    = 1'b1;
            rd_data       = ddr_rdata;
            rd_data_valid = ddr_rvalid;
            rd_done       = ddr_rvalid && ddr_rlast;
         end
         default: ;
      endcase
   end

   // Burst context is latched at grant; address/len registers feed both AW and AR.
   always_comb begin
      addr_d     = addr_q;
      len_d      = len_q;
      beat_cnt_d = beat_cnt_q;
      if (wr_grant) begin
         addr_d     = wr_addr;
         len_d      = wr_len;
         beat_cnt_d = '0;
      end else if (rd_grant) begin
         addr_d     = rd_addr;
         len_d      = rd_len;
         beat_cnt_d = '0;
      end else if (w_fire) begin
         beat_cnt_d = beat_cnt_q + 1'b1;
      end
   end

   always_comb begin
      wr_done_d  = (state_q == ST_WR_RESP) && ddr_bvalid;
      resp_err_d = resp_err_q;
      if ((state_q == ST_WR_RESP) && ddr_bvalid && (ddr_bresp != AXI_RESP_OKAY)) begin
         resp_err_d = 1'b1;
      end
      if ((state_q == ST_RD_DATA) && ddr_rvalid && (ddr_rresp != AXI_RESP_OKAY)) begin
         resp_err_d = 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         addr_q     <= '0;
         len_q      <= '0;
         beat_cnt_q <= '0;
         resp_err_q <= 1'b0;
         wr_done_q  <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         len_q      <= len_d;
         beat_cnt_q <= beat_cnt_d;
         resp_err_q <= resp_err_d;
         wr_done_q  <= wr_done_d;
      end
   end

   assign wr_done    = wr_done_q;
   assign resp_err   = resp_err_q;
   assign ddr_awid   = '0;
   assign ddr_arid   = '0;
   assign ddr_awaddr = addr_q;
   assign ddr_awlen  = len_q;
   assign ddr_araddr = addr_q;
   assign ddr_arlen  = len_q;

endmodule
